dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder that services the command/address/data requests driven by the MEM pipeline stage.
- Word-organised SRAM model with byte-lane stores, a configurable wait-state FSM and a one-cycle ready pulse. Hazard logic uses the ready pulse to stall the pipe.
- Returns the full aligned word. Byte/halfword extraction and sign extension stay in the MEM stage.
- Stores arrive with unshifted data (rs2 value); this block steers the data onto byte lanes.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words.
- WAIT_CYC, 2, wait states per access, legal range 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- MEM_mem_cmd  input  4  command: `MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW from sys_defs.vh.
- MEM_mem_addr  input  32  byte address.
- MEM_mem_din  input  32  store data, unshifted, LSB-justified.
- DM_mem_dout  output  32  aligned word read, registered.
- DM_ready  output  1  one-cycle completion pulse.
- DM_misalign  output  1  misaligned access flag, valid with DM_ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, DM_mem_dout=0, DM_ready=0, DM_misalign=0.
  - Array contents are not reset.
  - Reset during WAIT aborts the access; no write occurs.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Any legal non-NONE cmd is accepted. cmd, addr and din are captured into request registers.
  - Next state is WAIT with counter=WAIT_CYC, or the access edge directly if WAIT_CYC=0.
  - `MEM_NONE and undefined codes are ignored; the FSM stays in IDLE.
- WAIT:
  - counter decrements each cycle.
  - The edge leaving WAIT with counter==1 is the access edge.
- Access edge: the write is performed, DM_mem_dout is loaded, DM_ready<=1, and the FSM enters DONE.
- Latency: request accepted in cycle N gives DM_ready=1 in cycle N+WAIT_CYC+1.
- DONE:
  - DM_ready=1 for exactly this cycle. Next state is IDLE and DM_ready<=0.
  - A new request is accepted no earlier than the cycle after DONE.
- The requester holds cmd stable until DM_ready. The captured copy is authoritative; input changes during WAIT are ignored.
- Word index = addr[ADDR_W+1:2]. Higher address bits are ignored (aliasing).
- Loads (LB/LH/LW/LBU/LHU): DM_mem_dout = the full array word at the index. Its value is held until the next access edge.
- Store lane enables:
  - SB: lane addr[1:0], written with din[7:0].
  - SH: lanes {2*addr[1]+1, 2*addr[1]}, written with din[15:0].
  - SW: all four lanes, written with din.
- Stores leave DM_mem_dout unchanged.
- Misalignment:
  - Condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Effect: DM_misalign=1 together with DM_ready.
  - Stores: the write is suppressed.
  - Loads: the aligned word is still returned.
  - DM_misalign clears with DM_ready.

Optional Feature:
- Macro DMEM_POSTED_WR_EN.
- Defined: stores bypass WAIT. The write happens on the acceptance edge and DM_ready is asserted at N+1, regardless of WAIT_CYC. Loads keep N+WAIT_CYC+1.
- Undefined: stores and loads share identical WAIT_CYC timing.

Test Plan:
- Word round trip (WAIT_CYC=2): SW addr 0x10 din 0xDEADBEEF, then LW 0x10 -> each DM_ready lands 3 cycles after accept; DM_mem_dout=0xDEADBEEF, DM_misalign=0.
- Byte store: SB addr 0x11 din 0x000000AA, then LW 0x10 -> 0xDEADAAEF.
- Halfword store: SH addr 0x12 din 0xFFFF1234, then LW 0x10 -> 0x1234AAEF.
- Misalignment:
  - LW addr 0x12 -> DM_ready=1 with DM_misalign=1, DM_mem_dout=0x1234AAEF.
  - SW addr 0x13 din 0x0 -> misalign=1; a subsequent LW 0x10 still returns 0x1234AAEF.
- Reset mid-access: SW 0x20 din 0x55 (0x20 previously holds 0x0); assert rst in the WAIT cycle -> outputs 0 immediately; after release, LW 0x20 returns 0x0.
- Idle and posted-write behaviour:
  - Hold `MEM_NONE and an undefined code for 10 cycles each -> DM_ready never asserts.
  - With DMEM_POSTED_WR_EN defined: SW -> DM_ready at N+1 while LW stays at N+3.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the MEM pipeline stage. It models a word-organised
//   SRAM with byte-lane stores, a programmable number of wait states and a
//   one-cycle completion pulse that the hazard logic uses to stall the pipe.
//   Loads return the full aligned word; byte/halfword extraction and sign
//   extension stay in the MEM stage. Store data arrives LSB-justified and is
//   steered onto the addressed byte lanes here.
//
// Parameters
//   ADDR_W    word-address bits (depth = 2**ADDR_W words)
//   WAIT_CYC  wait states per access, 0..15
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   MEM_mem_cmd   4-bit memory command (encodings below)
//   MEM_mem_addr  byte address
//   MEM_mem_din   store data, unshifted, LSB-justified
//   DM_mem_dout   aligned word from the last load (registered, held)
//   DM_ready      one-cycle completion pulse
//   DM_misalign   misaligned-access flag, valid with DM_ready
//
// Handshake: the requester presents a command while the responder is idle and
//   holds it stable until DM_ready. The command is captured on acceptance and
//   the captured copy is authoritative; DM_ready is high for exactly one cycle
//   and a new request is taken no earlier than the cycle after that pulse.
//
// Build option
//   DMEM_POSTED_WR_EN  when defined, stores skip the wait states: the write
//                      happens on the acceptance edge and DM_ready follows one
//                      cycle later. Loads keep the WAIT_CYC timing.
module dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_addr,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic        DM_ready,
  output logic        DM_misalign
);

  // Command encodings shared with the pipeline (sys_defs.vh); 9..15 undefined.
  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

`ifdef DMEM_POSTED_WR_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic is_legal(input logic [3:0] c);
    return (c != MEM_NONE) && (c <= MEM_SW);
  endfunction

  function automatic logic is_store(input logic [3:0] c);
    return (c == MEM_SB) || (c == MEM_SH) || (c == MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] c, input logic [1:0] a);
    case (c)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return (a != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_din;

  // Access-edge view: straight from the inputs when the access happens on the
  // acceptance edge (no wait states, or a posted store), else the captured copy.
  logic              acc_fire;
  logic [3:0]        acc_cmd;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_din;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_mis;
  logic [3:0]        acc_be;
  logic [31:0]       acc_wdata;
  logic              mem_we;
  logic              unused_addr_bits;

  always_comb begin
    acc_fire = 1'b0;
    acc_cmd  = req_cmd;
    acc_addr = req_addr;
    acc_din  = req_din;
    case (state)
      IDLE: begin
        acc_cmd  = MEM_mem_cmd;
        acc_addr = MEM_mem_addr;
        acc_din  = MEM_mem_din;
        if (is_legal(MEM_mem_cmd) &&
            ((WAIT_CYC == 0) || (POSTED_WR && is_store(MEM_mem_cmd))))
          acc_fire = 1'b1;
      end
      WAIT:    acc_fire = (cnt == 4'd1);
      default: acc_fire = 1'b0;
    endcase
  end

  // Upper address bits alias onto the same words.
  assign acc_idx          = acc_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^acc_addr[31:ADDR_W+2];
  assign acc_mis          = is_misaligned(acc_cmd, acc_addr[1:0]);

  always_comb begin
    acc_be    = 4'b0000;
    acc_wdata = acc_din;
    case (acc_cmd)
      MEM_SB: begin
        acc_be    = 4'b0001 << acc_addr[1:0];
        acc_wdata = {4{acc_din[7:0]}};
      end
      MEM_SH: begin
        acc_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{acc_din[15:0]}};
      end
      MEM_SW: begin
        acc_be    = 4'b1111;
        acc_wdata = acc_din;
      end
      default: begin
        acc_be    = 4'b0000;
        acc_wdata = acc_din;
      end
    endcase
  end

  // Misaligned stores are dropped; reset kills any pending write.
  assign mem_we = acc_fire && is_store(acc_cmd) && !acc_mis && rst;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      req_cmd     <= MEM_NONE;
      req_addr    <= 32'd0;
      req_din     <= 32'd0;
      DM_mem_dout <= 32'd0;
      DM_ready    <= 1'b0;
      DM_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_legal(MEM_mem_cmd)) begin
            req_cmd  <= MEM_mem_cmd;
            req_addr <= MEM_mem_addr;
            req_din  <= MEM_mem_din;
            if (!acc_fire) begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (!acc_fire) cnt <= cnt - 4'd1;
        end
        DONE: begin
          state       <= IDLE;
          DM_ready    <= 1'b0;
          DM_misalign <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (acc_fire) begin
        state       <= DONE;
        cnt         <= 4'd0;
        DM_ready    <= 1'b1;
        DM_misalign <= acc_mis;
        // Misaligned loads still return the aligned word.
        if (!is_store(acc_cmd)) DM_mem_dout <= mem[acc_idx];
      end
    end
  end

endmodule
